img_stream_loader: RTL and testbench

IMG_STREAM_LOADER -- requirements
Module: img_stream_loader

---
 rtl/img_stream_loader.sv | 201 ++++++++++++++++++++
 tb/tb_img_stream_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_loader.sv
// Ping-pong image buffer: loads binary pixel images from a beat stream into one
// bank while the other bank is scanned out column by column, ROWS pixels at a time.
module img_stream_loader #(
    parameter int WIDTH   = 28,
    parameter int HEIGHT  = 28,
    parameter int TDATA_W = 128,
    parameter int ROWS    = 8,
    localparam int PIX      = WIDTH * HEIGHT,
    localparam int BEATS    = (PIX + TDATA_W - 1) / TDATA_W,
    localparam int GROUPS   = (HEIGHT + ROWS - 1) / ROWS,
    localparam int MEM_BITS = BEATS * TDATA_W,
    localparam int COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int GRP_W    = $clog2(GROUPS) + 1,
    localparam int BCNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int MIDX_W   = $clog2(MEM_BITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TDATA_W-1:0] s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    output logic               img_ready,
    input  logic               rd_start,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ROWS-1:0]    rd_pixels,
    output logic [COL_W-1:0]   rd_col,
    output logic [GRP_W-1:0]   rd_group,
    output logic               rd_done,
    input  logic               img_release,
    output logic               err_tlast,
    input  logic               err_clr
);

    typedef enum logic [1:0] {B_EMPTY, B_LOADING, B_FULL, B_READING} bank_state_t;
    typedef enum logic [1:0] {R_IDLE, R_SCAN, R_HOLD} rd_state_t;

    bank_state_t         bank_reg [2];
    logic                wb_reg;
    logic                rb_reg;
    logic [BCNT_W-1:0]   beat_cnt_reg;
    logic                err_tlast_reg;
    rd_state_t           rd_state_reg;
    logic                rd_valid_reg;
    logic                rd_done_reg;
    logic [COL_W-1:0]    rd_col_reg;
    logic [GRP_W-1:0]    rd_group_reg;
    logic [ROWS-1:0]     rd_pixels_reg;

    // Pixel storage is deliberately left out of reset; bank state alone marks validity.
    logic [MEM_BITS-1:0] bank_mem [2];

    logic                s_tready_int;
    logic                beat_fire;
    logic                beat_last;
    logic                err_set;
    logic                img_ready_int;
    logic                scan_start;
    logic                rd_accept;
    logic                scan_last;
    logic [MIDX_W-1:0]   wr_base;
    logic [COL_W-1:0]    col_next;
    logic [GRP_W-1:0]    grp_next;
    logic [ROWS-1:0]     pix_next;

    assign s_tready_int  = (bank_reg[wb_reg] == B_EMPTY) || (bank_reg[wb_reg] == B_LOADING);
    assign beat_fire     = s_tvalid && s_tready_int;
    assign beat_last     = (beat_cnt_reg == BCNT_W'(BEATS - 1));
    // A framing error is tlast arriving anywhere other than the final beat, or missing on it.
    assign err_set       = beat_fire && (beat_last != s_tlast);
    assign img_ready_int = (bank_reg[rb_reg] == B_FULL);
    assign scan_start    = (rd_state_reg == R_IDLE) && rd_start && img_ready_int;
    assign rd_accept     = (rd_state_reg == R_SCAN) && rd_valid_reg && rd_ready;
    assign scan_last     = (rd_col_reg == COL_W'(WIDTH - 1)) && (rd_group_reg == GRP_W'(GROUPS - 1));
    assign wr_base       = MIDX_W'(32'(beat_cnt_reg) * 32'(TDATA_W));

    always_ff @(posedge clk) begin
        if (beat_fire) begin
            bank_mem[wb_reg][wr_base +: TDATA_W] <= s_tdata;
        end
    end

    // Position of the column presented after this edge.
    always_comb begin
        col_next = rd_col_reg;
        grp_next = rd_group_reg;
        if (scan_start) begin
            col_next = '0;
            grp_next = '0;
        end else if (rd_accept) begin
            if (rd_col_reg == COL_W'(WIDTH - 1)) begin
                col_next = '0;
                grp_next = rd_group_reg + 1'b1;
            end else begin
                col_next = rd_col_reg + 1'b1;
            end
        end
    end

    // One bit-select per output row; rows past the image bottom read as zero.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [31:0]       row_idx;
            logic [MIDX_W-1:0] pix_idx;
            assign row_idx      = 32'(grp_next) * 32'(ROWS) + 32'(gi);
            assign pix_idx      = MIDX_W'(row_idx * 32'(WIDTH) + 32'(col_next));
            assign pix_next[gi] = (row_idx < 32'(HEIGHT)) ? bank_mem[rb_reg][pix_idx] : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_reg[0]   <= B_EMPTY;
            bank_reg[1]   <= B_EMPTY;
            wb_reg        <= 1'b0;
            rb_reg        <= 1'b0;
            beat_cnt_reg  <= '0;
            err_tlast_reg <= 1'b0;
            rd_state_reg  <= R_IDLE;
            rd_valid_reg  <= 1'b0;
            rd_done_reg   <= 1'b0;
            rd_col_reg    <= '0;
            rd_group_reg  <= '0;
            rd_pixels_reg <= '0;
        end else begin
            rd_done_reg <= 1'b0;

            if (beat_fire) begin
                if (beat_last) begin
                    bank_reg[wb_reg] <= B_FULL;
                    wb_reg           <= ~wb_reg;
                    beat_cnt_reg     <= '0;
                end else if (s_tlast) begin
                    bank_reg[wb_reg] <= B_EMPTY;
                    beat_cnt_reg     <= '0;
                end else begin
                    bank_reg[wb_reg] <= B_LOADING;
                    beat_cnt_reg     <= beat_cnt_reg + 1'b1;
                end
            end

            if (err_set) begin
                err_tlast_reg <= 1'b1;
            end else if (err_clr) begin
                err_tlast_reg <= 1'b0;
            end

            // Read-side bank updates never collide with the write side: the
            // read bank is FULL/READING while the write bank is EMPTY/LOADING.
            case (rd_state_reg)
                R_IDLE: begin
                    if (scan_start) begin
                        bank_reg[rb_reg] <= B_READING;
                        rd_state_reg     <= R_SCAN;
                        rd_valid_reg     <= 1'b1;
                        rd_col_reg       <= col_next;
                        rd_group_reg     <= grp_next;
                        rd_pixels_reg    <= pix_next;
                    end
                end
                R_SCAN: begin
                    if (rd_accept) begin
                        if (scan_last) begin
                            rd_state_reg  <= R_HOLD;
                            rd_valid_reg  <= 1'b0;
                            rd_done_reg   <= 1'b1;
                            rd_col_reg    <= '0;
                            rd_group_reg  <= '0;
                            rd_pixels_reg <= '0;
                        end else begin
                            rd_col_reg    <= col_next;
                            rd_group_reg  <= grp_next;
                            rd_pixels_reg <= pix_next;
                        end
                    end
                end
                R_HOLD: begin
                    if (img_release) begin
                        bank_reg[rb_reg] <= B_EMPTY;
                        rb_reg           <= ~rb_reg;
                        rd_state_reg     <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    assign s_tready  = s_tready_int;
    assign img_ready = img_ready_int;
    assign rd_valid  = rd_valid_reg;
    assign rd_pixels = rd_pixels_reg;
    assign rd_col    = rd_col_reg;
    assign rd_group  = rd_group_reg;
    assign rd_done   = rd_done_reg;
    assign err_tlast = err_tlast_reg;

endmodule

// File: tb/tb_img_stream_loader.sv
// Directed-plus-random bench for img_stream_loader; expected readout is derived
// from whole images held in the bench and simple row/column arithmetic.
module tb_img_stream_loader;

    localparam int WIDTH      = 28;
    localparam int HEIGHT     = 28;
    localparam int TDATA_W    = 128;
    localparam int ROWS       = 8;
    localparam int PIX        = WIDTH * HEIGHT;
    localparam int BEATS      = (PIX + TDATA_W - 1) / TDATA_W;
    localparam int GROUPS     = (HEIGHT + ROWS - 1) / ROWS;
    localparam int COLS_TOTAL = WIDTH * GROUPS;
    localparam int COL_W      = $clog2(WIDTH);
    localparam int GRP_W      = $clog2(GROUPS) + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [TDATA_W-1:0] s_tdata;
    logic               s_tvalid;
    logic               s_tlast;
    logic               s_tready;
    logic               img_ready;
    logic               rd_start;
    logic               rd_ready;
    logic               rd_valid;
    logic [ROWS-1:0]    rd_pixels;
    logic [COL_W-1:0]   rd_col;
    logic [GRP_W-1:0]   rd_group;
    logic               rd_done;
    logic               img_release;
    logic               err_tlast;
    logic               err_clr;

    int errors = 0;
    int checks = 0;
    int held   = 0;

    img_stream_loader #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .TDATA_W(TDATA_W), .ROWS(ROWS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .img_ready(img_ready), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pixels(rd_pixels), .rd_col(rd_col), .rd_group(rd_group),
        .rd_done(rd_done), .img_release(img_release),
        .err_tlast(err_tlast), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PIX-1:0] checker_img();
        logic [PIX-1:0] m;
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++)
                m[r*WIDTH + c] = 1'((r + c) % 2);
        return m;
    endfunction

    function automatic logic [PIX-1:0] rand_img();
        logic [PIX-1:0] m;
        for (int i = 0; i < PIX; i++) m[i] = 1'($urandom_range(1));
        return m;
    endfunction

    // Column c of row group g: pixel of each row in the group, zero below the image.
    function automatic logic [ROWS-1:0] exp_pix(input logic [PIX-1:0] img, input int g, input int c);
        logic [ROWS-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            int row;
            row = g * ROWS + r;
            if (row < HEIGHT) v[r] = img[row*WIDTH + c];
            else              v[r] = 1'b0;
        end
        return v;
    endfunction

    task automatic send_image(input logic [PIX-1:0] img, input int nbeats, input int tlast_beat);
        logic [TDATA_W-1:0] beat;
        for (int b = 0; b < nbeats; b++) begin
            int w;
            for (int i = 0; i < TDATA_W; i++) begin
                int p;
                p = b * TDATA_W + i;
                if (p < PIX) beat[i] = img[p];
                else         beat[i] = 1'($urandom_range(1));
            end
            s_tdata  = beat;
            s_tvalid = 1'b1;
            s_tlast  = (b == tlast_beat);
            w = 0;
            while (!s_tready && w < 500) begin
                step();
                w++;
            end
            if (w >= 500) begin
                chk("s_tready_timeout", s_tready, 1'b1);
                break;
            end
            step();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        $display("load: beats=%0d tlast_beat=%0d", nbeats, tlast_beat);
    endtask

    task automatic scan_image(input logic [PIX-1:0] img, input int ready_pct);
        int k = 0, cyc = 0, vcyc = 0, dones = 0;
        logic hold = 1'b0;
        logic [COL_W-1:0] pc = '0;
        logic [GRP_W-1:0] pg = '0;
        logic [ROWS-1:0]  pp = '0;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        chk("rd_valid_after_start", rd_valid, 1'b1);
        while (k < COLS_TOTAL && cyc < 5000) begin
            if (hold) chk("hold_stable", {rd_col, rd_group, rd_pixels}, {pc, pg, pp});
            if (!rd_valid) chk("rd_valid_gap", rd_valid, 1'b1);
            if (rd_done) dones++;
            rd_ready = ($urandom_range(99) < ready_pct);
            if (rd_valid) begin
                vcyc++;
                if (rd_ready) begin
                    chk("rd_position", {rd_group, rd_col}, {GRP_W'(k / WIDTH), COL_W'(k % WIDTH)});
                    chk("rd_pixels", rd_pixels, exp_pix(img, k / WIDTH, k % WIDTH));
                    k++;
                end
            end
            hold = rd_valid && !rd_ready;
            pc = rd_col;
            pg = rd_group;
            pp = rd_pixels;
            step();
            cyc++;
        end
        chk("scan_columns", k, COLS_TOTAL);
        chk("rd_done_early", dones, 0);
        chk("rd_valid_dropped", rd_valid, 1'b0);
        chk("rd_done_pulse", rd_done, 1'b1);
        if (ready_pct == 100) chk("valid_cycles", vcyc, COLS_TOTAL);
        rd_ready = 1'b0;
        step();
        chk("rd_done_single", rd_done, 1'b0);
        $display("scan: ready_pct=%0d columns=%0d valid_cycles=%0d", ready_pct, k, vcyc);
    endtask

    task automatic release_image();
        img_release = 1'b1;
        step();
        img_release = 1'b0;
        held--;
        $display("release: held=%0d", held);
    endtask

    initial begin
        logic [PIX-1:0] cb, img_c, img_d, img_e, img_f, img_g, img_h;
        int w;
        rst_n = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        rd_start = 1'b0; rd_ready = 1'b0; img_release = 1'b0; err_clr = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_s_tready", s_tready, 1'b1);
        chk("rst_img_ready", img_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_done", rd_done, 1'b0);
        chk("rst_err_tlast", err_tlast, 1'b0);
        chk("rst_rd_col", rd_col, '0);
        chk("rst_rd_group", rd_group, '0);
        chk("rst_rd_pixels", rd_pixels, '0);

        // Clean checkerboard load, then full-rate and random-rate scans.
        cb = checker_img();
        send_image(cb, BEATS, BEATS - 1);
        held++;
        chk("img_ready_after_load", img_ready, 1'b1);
        chk("s_tready_after_load", s_tready, 1'b1);
        chk("err_after_clean", err_tlast, 1'b0);
        scan_image(cb, 100);
        release_image();
        chk("img_ready_after_release", img_ready, 1'b0);
        send_image(cb, BEATS, BEATS - 1);
        held++;
        scan_image(cb, 50);
        release_image();

        // Three images back to back: the third stalls until a bank is released.
        img_c = rand_img();
        img_d = rand_img();
        img_e = rand_img();
        send_image(img_c, BEATS, BEATS - 1);
        held++;
        send_image(img_d, BEATS, BEATS - 1);
        held++;
        chk("s_tready_two_held", s_tready, held < 2);
        chk("img_ready_two_held", img_ready, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = {4{$urandom()}};
        repeat (5) step();
        chk("s_tready_stalled", s_tready, 1'b0);
        scan_image(img_c, 100);
        chk("s_tready_before_release", s_tready, 1'b0);
        release_image();
        chk("s_tready_after_release", s_tready, held < 2);
        fork
            send_image(img_e, BEATS, BEATS - 1);
            scan_image(img_d, 50);
        join
        held++;
        release_image();
        chk("img_ready_third", img_ready, 1'b1);
        scan_image(img_e, 100);
        release_image();

        // Early tlast discards the image; the next clean image still loads.
        img_f = rand_img();
        send_image(img_f, 4, 3);
        chk("err_early_tlast", err_tlast, 1'b1);
        chk("img_ready_discard", img_ready, 1'b0);
        chk("s_tready_discard", s_tready, 1'b1);
        send_image(img_f, BEATS, BEATS - 1);
        held++;
        chk("img_ready_after_err", img_ready, 1'b1);
        chk("err_sticky", err_tlast, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared", err_tlast, 1'b0);
        scan_image(img_f, 100);
        release_image();

        // Missing tlast on the final beat: image kept, error flagged.
        img_g = rand_img();
        send_image(img_g, BEATS, -1);
        held++;
        chk("err_missing_tlast", err_tlast, 1'b1);
        chk("img_ready_missing_tlast", img_ready, 1'b1);
        scan_image(img_g, 50);
        release_image();
        err_clr = 1'b1;
        step();
        chk("err_cleared2", err_tlast, 1'b0);
        // Clear held high while a new error occurs: the error wins.
        send_image(img_g, 2, 1);
        err_clr = 1'b0;
        chk("err_set_wins", err_tlast, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared3", err_tlast, 1'b0);

        // Reset in the middle of a scan.
        img_h = rand_img();
        send_image(img_h, BEATS, BEATS - 1);
        held++;
        rd_ready = 1'b1;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        w = 0;
        while (rd_col != COL_W'(10) && w < 100) begin
            step();
            w++;
        end
        chk("reached_col10", rd_col, COL_W'(10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_valid", rd_valid, 1'b0);
        chk("midrst_rd_col", rd_col, '0);
        chk("midrst_rd_group", rd_group, '0);
        chk("midrst_rd_pixels", rd_pixels, '0);
        chk("midrst_rd_done", rd_done, 1'b0);
        chk("midrst_img_ready", img_ready, 1'b0);
        step();
        rst_n = 1'b1;
        rd_ready = 1'b0;
        held = 0;
        repeat (3) begin
            step();
            chk("postrst_no_done", rd_done, 1'b0);
        end
        chk("postrst_img_ready", img_ready, 1'b0);
        chk("postrst_s_tready", s_tready, 1'b1);
        $display("reset: abandoned scan at column 10");

        send_image(cb, BEATS, BEATS - 1);
        held++;
        scan_image(cb, 100);
        release_image();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
